// File: rtl/phy_reg_freelist_if.sv
// Rename/commit side of the physical-register free list: grant, release, rollback and status.
interface phy_reg_freelist_if #(
    parameter int PREG_W = 7
);
    logic              alloc_req;
    logic              alloc_valid;
    logic [PREG_W-1:0] alloc_preg;
    logic              commit_en;
    logic              free_en;
    logic [PREG_W-1:0] free_preg;
    logic              flush;
    logic [PREG_W-1:0] free_cnt;
    logic              err;

    modport master (
        output alloc_req, commit_en, free_en, free_preg, flush,
        input  alloc_valid, alloc_preg, free_cnt, err
    );

    modport slave (
        input  alloc_req, commit_en, free_en, free_preg, flush,
        output alloc_valid, alloc_preg, free_cnt, err
    );
endinterface

// File: rtl/phy_reg_freelist.sv
// Physical-register free list: circular buffer with speculative head, architectural head and tail.
// Latency: grant is combinational from the speculative head; frees are grantable the cycle after.
// Backpressure: alloc_valid drops when no speculative entry remains; flush suppresses grants.
module phy_reg_freelist #(
    parameter int NUM_PHY  = 128,
    parameter int NUM_ARCH = 32,
    parameter int PREG_W   = $clog2(NUM_PHY)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    phy_reg_freelist_if.slave    fl
);
    localparam int DEPTH = NUM_PHY - NUM_ARCH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PREG_W-1:0] entries_q [DEPTH];
    logic [PREG_W-1:0] entries_d [DEPTH];
    logic [PTR_W-1:0]  spec_head_q, spec_head_d;
    logic [PTR_W-1:0]  arch_head_q, arch_head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  spec_cnt_q, spec_cnt_d;
    logic [CNT_W-1:0]  arch_cnt_q, arch_cnt_d;
    logic              err_q, err_d;

    logic alloc_valid;
    logic alloc_fire;
    logic free_ok;
    logic free_wr;
    logic full;
    logic outstanding;
    logic commit_ok;

    // DEPTH is not a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign alloc_valid = (spec_cnt_q != '0);
    assign alloc_fire  = fl.alloc_req & alloc_valid & ~fl.flush;
    assign free_ok     = fl.free_en & (fl.free_preg != '0);
    assign full        = (arch_cnt_q == CNT_W'(DEPTH));
    assign free_wr     = free_ok & ~full;
    assign outstanding = (arch_cnt_q != spec_cnt_q);
    assign commit_ok   = fl.commit_en & outstanding;

    always_comb begin
        entries_d = entries_q;
        if (free_wr) begin
            entries_d[tail_q] = fl.free_preg;
        end

        tail_d      = free_wr   ? ptr_inc(tail_q)      : tail_q;
        arch_head_d = commit_ok ? ptr_inc(arch_head_q) : arch_head_q;
        arch_cnt_d  = arch_cnt_q - CNT_W'(commit_ok) + CNT_W'(free_wr);

        // Commit and free land first; a flush then rolls the speculative view back onto them.
        if (fl.flush) begin
            spec_head_d = arch_head_d;
            spec_cnt_d  = arch_cnt_d;
        end else begin
            spec_head_d = alloc_fire ? ptr_inc(spec_head_q) : spec_head_q;
            spec_cnt_d  = spec_cnt_q - CNT_W'(alloc_fire) + CNT_W'(free_wr);
        end

        err_d = err_q | (free_ok & full) | (fl.commit_en & ~outstanding);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= PREG_W'(NUM_ARCH + i);
            end
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= '0;
            spec_cnt_q  <= CNT_W'(DEPTH);
            arch_cnt_q  <= CNT_W'(DEPTH);
            err_q       <= 1'b0;
        end else begin
            entries_q   <= entries_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            spec_cnt_q  <= spec_cnt_d;
            arch_cnt_q  <= arch_cnt_d;
            err_q       <= err_d;
        end
    end

    assign fl.alloc_valid = alloc_valid;
    assign fl.alloc_preg  = entries_q[spec_head_q];
    assign fl.free_cnt    = PREG_W'(spec_cnt_q);
    assign fl.err         = err_q;
endmodule

// File: tb/tb_phy_reg_freelist.sv
// Directed and model-based bench for the physical-register free list.
module tb_phy_reg_freelist;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    phy_reg_freelist_if #(.PREG_W(7)) fl_if ();

    phy_reg_freelist dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl    (fl_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       req;
        logic       commit;
        logic       fen;
        logic [6:0] fpreg;
        logic       flush;
        logic       exp_valid;
        int         exp_preg;   // negative: don't care
        int         exp_cnt;
        logic       exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic req, input logic commit, input logic fen, input int fp,
                                input logic flush, input logic ev, input int ep, input int ec,
                                input logic ee);
        vec_t v;
        v.req = req; v.commit = commit; v.fen = fen; v.fpreg = fp[6:0]; v.flush = flush;
        v.exp_valid = ev; v.exp_preg = ep; v.exp_cnt = ec; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic commit, input logic fen,
                         input logic [6:0] fp, input logic flush);
        fl_if.alloc_req = req;
        fl_if.commit_en = commit;
        fl_if.free_en   = fen;
        fl_if.free_preg = fp;
        fl_if.flush     = flush;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 2ns later.
    task automatic apply(input vec_t v, input string tag);
        drive(v.req, v.commit, v.fen, v.fpreg, v.flush);
        #2;
        chk({tag, "_valid"}, fl_if.alloc_valid, v.exp_valid);
        if (v.exp_preg >= 0) chk({tag, "_preg"}, fl_if.alloc_preg, v.exp_preg);
        chk({tag, "_cnt"}, fl_if.free_cnt, v.exp_cnt);
        chk({tag, "_err"}, fl_if.err, v.exp_err);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        chk({tag, "_rst_valid"}, fl_if.alloc_valid, 1);
        chk({tag, "_rst_preg"}, fl_if.alloc_preg, 32);
        chk({tag, "_rst_cnt"}, fl_if.free_cnt, 96);
        chk({tag, "_rst_err"}, fl_if.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int arch_q[$];
    int pool[$];
    bit mapped[128];
    int n_out;

    initial begin
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);

        // Drain the whole list: 32..127 in order, then empty.
        do_reset("t1");
        for (int k = 0; k < 96; k++) apply(mk(1, 0, 0, 0, 0, 1, 32 + k, 96 - k, 0), $sformatf("t1_%0d", k));
        apply(mk(1, 0, 0, 0, 0, 0, -1, 0, 0), "t1_empty");

        // Retire everything, then refill from empty; a free in the empty cycle is not granted.
        for (int k = 0; k < 96; k++) apply(mk(0, 1, 0, 0, 0, 0, -1, 0, 0), $sformatf("t2_cm%0d", k));
        apply(mk(1, 0, 1, 40, 0, 0, -1, 0, 0), "t2_a");
        apply(mk(0, 0, 1, 41, 0, 1, 40, 1, 0), "t2_b");
        apply(mk(0, 0, 1, 42, 0, 1, 40, 2, 0), "t2_c");
        apply(mk(1, 0, 0, 0, 0, 1, 40, 3, 0), "t2_d");
        apply(mk(1, 0, 0, 0, 0, 1, 41, 2, 0), "t2_e");
        apply(mk(1, 0, 0, 0, 0, 1, 42, 1, 0), "t2_f");
        apply(mk(1, 0, 0, 0, 0, 0, -1, 0, 0), "t2_g");

        // Rollback after partial commit, then a cycle with alloc+commit+free+flush together.
        do_reset("t3");
        for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32 + i, 96 - i, 0));
        for (int i = 0; i < 4; i++)  tbl.push_back(mk(0, 1, 0, 0, 0, 1, 42, 86, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 42, 86, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 36, 92, 0));
        tbl.push_back(mk(1, 1, 1, 50, 1, 1, 37, 91, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 37, 92, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("t34_%0d", i));

        // The freed p50 sits at ring index 0, reached after 38..127.
        for (int k = 0; k < 90; k++) apply(mk(1, 0, 0, 0, 0, 1, 38 + k, 91 - k, 0), $sformatf("t4_%0d", k));
        apply(mk(1, 0, 0, 0, 0, 1, 50, 1, 0), "t4_tail");
        apply(mk(1, 0, 0, 0, 0, 0, -1, 0, 0), "t4_empty");

        // Protocol corners: p0 drop, free at full, bad commit, sticky err.
        do_reset("t5");
        apply(mk(0, 0, 1, 0, 0, 1, 32, 96, 0), "t5_p0");
        apply(mk(0, 0, 0, 0, 0, 1, 32, 96, 0), "t5_p0_after");
        apply(mk(0, 0, 1, 50, 0, 1, 32, 96, 0), "t5_full");
        apply(mk(0, 0, 0, 0, 0, 1, 32, 96, 1), "t5_full_err");
        do_reset("t5b");
        apply(mk(0, 1, 0, 0, 0, 1, 32, 96, 0), "t5_badcm");
        apply(mk(1, 0, 0, 0, 0, 1, 32, 96, 1), "t5_badcm_err");
        apply(mk(0, 0, 0, 0, 1, 1, 33, 95, 1), "t5_sticky");
        apply(mk(0, 0, 0, 0, 0, 1, 32, 96, 1), "t5_archhead");
        apply(mk(1, 0, 0, 0, 0, 1, 32, 96, 1), "t5_mid_a");
        apply(mk(1, 0, 0, 0, 0, 1, 33, 95, 1), "t5_mid_b");
        do_reset("t5c");

        // Random traffic against a queue model of committed-free registers plus an outstanding count.
        arch_q.delete();
        pool.delete();
        for (int i = 32; i < 128; i++) arch_q.push_back(i);
        for (int i = 0; i < 128; i++) mapped[i] = (i > 0 && i < 32);
        for (int i = 1; i < 32; i++) pool.push_back(i);
        n_out = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic r_req, r_cm, r_fen, r_fl;
            logic [6:0] r_fp;
            int idx;
            int exp_cnt;
            logic fire;
            r_req = ($urandom_range(0, 2) != 0);
            r_cm  = (n_out > 0) && ($urandom_range(0, 1) == 1);
            r_fl  = ($urandom_range(0, 15) == 0);
            r_fen = 1'b0;
            r_fp  = 7'($urandom_range(0, 127));
            idx   = -1;
            if (pool.size() > 31 && $urandom_range(0, 2) == 0) begin
                idx   = $urandom_range(0, pool.size() - 1);
                r_fen = 1'b1;
                r_fp  = 7'(pool[idx]);
            end else if ($urandom_range(0, 19) == 0) begin
                r_fen = 1'b1;
                r_fp  = 7'd0;
            end
            drive(r_req, r_cm, r_fen, r_fp, r_fl);
            #2;
            exp_cnt = arch_q.size() - n_out;
            chk("rand_valid", fl_if.alloc_valid, (exp_cnt != 0));
            chk("rand_cnt", fl_if.free_cnt, exp_cnt);
            chk("rand_err", fl_if.err, 0);
            fire = r_req && (exp_cnt != 0) && !r_fl;
            if (exp_cnt != 0) chk("rand_preg", fl_if.alloc_preg, arch_q[n_out]);
            if (fire) chk("rand_live", mapped[fl_if.alloc_preg], 0);
            if (fire) n_out++;
            if (r_cm) begin
                int r;
                r = arch_q.pop_front();
                n_out--;
                pool.push_back(r);
                mapped[r] = 1'b1;
            end
            if (idx >= 0) begin
                mapped[pool[idx]] = 1'b0;
                arch_q.push_back(pool[idx]);
                pool.delete(idx);
            end
            if (r_fl) n_out = 0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
